// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- multi-cycle RV32M multiply/divide execute unit.
//
// Sits beside the single-cycle ALU in EX. A request accepted in IDLE is
// iterated in CALC for XLEN/UNROLL cycles (UNROLL shift-add or
// restoring-subtract steps per cycle). The unit then presents a one-cycle
// write-back in DONE.
//
// Parameters
//   XLEN    operand/result width (even power of two, >= 8)
//   UNROLL  bits retired per CALC cycle (1, 2 or 4; must divide XLEN)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous reset, active-low
//   start_i   request a new operation (sampled in IDLE only)
//   func3_i   RV32M func3: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   reg1_i    rs1 (multiplicand / dividend)
//   reg2_i    rs2 (multiplier / divisor)
//   wd_i      destination register address
//   flush_i   abort the in-flight operation
//   stallreq  combinational stall request to the upstream pipeline
//   done_o    result valid, one-cycle pulse
//   wdata_o   result (holds its last value outside DONE)
//   wd_o      destination address latched at start
//   wreg_o    register-write enable, equal to done_o
//
// Configuration macro
//   MULDIV_FASTPATH_EN  when defined, divide-by-zero, signed overflow and
//                       multiply with a zero operand finish straight from
//                       IDLE (done_o one cycle after the start cycle).
// ---------------------------------------------------------------------------
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            flush_i,
    output logic            stallreq,
    output logic            done_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    // Control state (asynchronously reset)
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0]      wd_q, wd_d;

    // Datapath state (loaded on accept, no reset needed)
    logic [XLEN-1:0] hi_q;       // partial product high half / partial remainder
    logic [XLEN-1:0] lo_q;       // multiplier being shifted out / dividend->quotient
    logic [XLEN-1:0] opb_q;      // multiplicand magnitude / divisor magnitude
    logic [2:0]      func3_q;
    logic            neg_res_q;  // negate product or quotient
    logic            neg_rem_q;  // negate remainder (dividend was negative)

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg2_if(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    // One shift-add step: add multiplicand if the current multiplier LSB is
    // set, then shift the whole {carry, hi, lo} right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                    input logic [XLEN-1:0] lo,
                                                    input logic [XLEN-1:0] mc);
        logic [XLEN:0] s;
        s = {1'b0, hi} + (lo[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
        return {s, lo[XLEN-1:1]};
    endfunction

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits and record the quotient bit.
    // With a zero divisor every step "fits", which yields an all-ones
    // quotient and leaves the dividend magnitude in the remainder.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                    input logic [XLEN-1:0] quo,
                                                    input logic [XLEN-1:0] dvs);
        logic [XLEN:0] r;
        logic [XLEN:0] t;
        r = {rem, quo[XLEN-1]};
        t = r - {1'b0, dvs};
        if (r >= {1'b0, dvs}) begin
            return {t[XLEN-1:0], quo[XLEN-2:0], 1'b1};
        end
        return {r[XLEN-1:0], quo[XLEN-2:0], 1'b0};
    endfunction

    // -----------------------------------------------------------------------
    // Operand decode for a new request
    // -----------------------------------------------------------------------
    logic            accept;
    logic            signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero;
    logic            neg_res_d, neg_rem_d;

    assign accept = (state_q == S_IDLE) && start_i && !flush_i;

    always_comb begin
        // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
        signed_a  = (func3_i == 3'b001) || (func3_i == 3'b010) ||
                    (func3_i[2] && !func3_i[0]);
        signed_b  = (func3_i == 3'b001) || (func3_i[2] && !func3_i[0]);
        a_neg     = signed_a && reg1_i[XLEN-1];
        b_neg     = signed_b && reg2_i[XLEN-1];
        mag_a     = neg_if(a_neg, reg1_i);
        mag_b     = neg_if(b_neg, reg2_i);
        div_zero  = (reg2_i == '0);
        // Divide by zero keeps the raw all-ones quotient. The remainder
        // path recovers reg1_i exactly by re-applying the dividend sign to
        // its own magnitude.
        neg_res_d = (a_neg ^ b_neg) && !(func3_i[2] && div_zero);
        neg_rem_d = a_neg;
    end

    // -----------------------------------------------------------------------
    // Fast path: results that need no iteration
    // -----------------------------------------------------------------------
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;

`ifdef MULDIV_FASTPATH_EN
    logic ovf;

    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        ovf      = func3_i[2] && !func3_i[0] &&
                   (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == {XLEN{1'b1}});
        if (!func3_i[2] && ((reg1_i == '0) || div_zero)) begin
            fast_hit = 1'b1;
            fast_res = '0;
        end else if (func3_i[2] && div_zero) begin
            fast_hit = 1'b1;
            fast_res = func3_i[1] ? reg1_i : {XLEN{1'b1}};
        end else if (ovf) begin
            fast_hit = 1'b1;
            fast_res = func3_i[1] ? {XLEN{1'b0}} : reg1_i;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // -----------------------------------------------------------------------
    // Iteration datapath: UNROLL steps per CALC cycle
    // -----------------------------------------------------------------------
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   calc_res;

    always_comb begin
        hi_n = hi_q;
        lo_n = lo_q;
        for (int k = 0; k < UNROLL; k++) begin
            if (func3_q[2]) begin
                {hi_n, lo_n} = div_step(hi_n, lo_n, opb_q);
            end else begin
                {hi_n, lo_n} = mul_step(hi_n, lo_n, opb_q);
            end
        end
    end

    // Final sign fixup and result select, evaluated on the last CALC cycle
    always_comb begin
        prod_fix = neg2_if(neg_res_q, {hi_n, lo_n});
        if (func3_q[2]) begin
            calc_res = func3_q[1] ? neg_if(neg_rem_q, hi_n) : neg_if(neg_res_q, lo_n);
        end else if (func3_q[1:0] == 2'b00) begin
            calc_res = prod_fix[XLEN-1:0];
        end else begin
            calc_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wd_d = wd_i;
                    if (fast_hit) begin
                        state_d = S_DONE;
                        wdata_d = fast_res;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(N);
                    end
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        wdata_d = calc_res;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hi_q      <= '0;
            lo_q      <= func3_i[2] ? mag_a : mag_b;
            opb_q     <= func3_i[2] ? mag_b : mag_a;
            func3_q   <= func3_i;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end else if (state_q == S_CALC) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // stallreq is combinational so the request cycle itself stalls; it is
    // forced low while reset is held even if start_i is asserted.
    assign stallreq = rst && (accept || (state_q == S_CALC));
    // A flush arriving in DONE still cancels the write-back.
    assign done_o   = (state_q == S_DONE) && !flush_i;
    assign wreg_o   = done_o;
    assign wdata_o  = wdata_q;
    assign wd_o     = wd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic [2:0]  func3;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        flush;

    logic        stall1, done1, wreg1;
    logic [31:0] wdata1;
    logic [4:0]  wdo1;
    logic        stall4, done4, wreg4;
    logic [31:0] wdata4;
    logic [4:0]  wdo4;

    int passed = 0;
    int total  = 0;
    int failed = 0;

`ifdef MULDIV_FASTPATH_EN
    localparam int LAT_FAST = 1;
`else
    localparam int LAT_FAST = 33;
`endif

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .func3_i(func3),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .flush_i(flush),
        .stallreq(stall1), .done_o(done1), .wdata_o(wdata1),
        .wd_o(wdo1), .wreg_o(wreg1)
    );

    ex_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start_i(start4), .func3_i(func3),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .flush_i(flush),
        .stallreq(stall4), .done_o(done4), .wdata_o(wdata4),
        .wd_o(wdo4), .wreg_o(wreg4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=0x%08h required=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation from the current cycle (entered at posedge+1 in
    // IDLE) and return the done_o latency, the result and the number of
    // cycles stallreq was high. Returns at posedge+1 of the first IDLE cycle.
    task automatic do_op(input int u, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wdv,
                         output int lat, output logic [31:0] res,
                         output logic [4:0] wdr, output logic wr, output int st);
        func3 = f; reg1 = a; reg2 = b; wd = wdv;
        if (u == 4) start4 = 1'b1; else start1 = 1'b1;
        lat = -1; st = 0; res = '0; wdr = '0; wr = 1'b0;
        @(negedge clk);
        if ((u == 4) ? stall4 : stall1) st++;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if ((u == 4) ? stall4 : stall1) st++;
            if ((u == 4) ? done4 : done1) begin
                lat = i;
                res = (u == 4) ? wdata4 : wdata1;
                wdr = (u == 4) ? wdo4 : wdo1;
                wr  = (u == 4) ? wreg4 : wreg1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic op_check(input string tag, input int u, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input int exp_lat);
        int          lat, st;
        logic [31:0] res;
        logic [4:0]  wdr;
        logic        wr;
        do_op(u, f, a, b, 5'd3, lat, res, wdr, wr, st);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall"}, 32'(st), 32'(exp_lat));
    endtask

    initial begin
        int          lat, st, done_seen;
        logic [31:0] res;
        logic [4:0]  wdr;
        logic        wr;

        rst = 1'b0; start1 = 1'b1; start4 = 1'b0; flush = 1'b0;
        func3 = 3'b000; reg1 = 32'd1; reg2 = 32'd1; wd = 5'd1;

        // Reset state, with start_i held high to show stallreq stays low
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_wreg", {31'd0, wreg1}, 32'd0);
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_wdata", wdata1, 32'd0);
        chk("rst_wd", {27'd0, wdo1}, 32'd0);
        start1 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // MUL 7 x -3 with full observation of wd/wreg/stall
        do_op(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd21, lat, res, wdr, wr, st);
        chk("mul_res", res, 32'hFFFF_FFEB);
        chk("mul_lat", 32'(lat), 32'd33);
        chk("mul_wd", {27'd0, wdr}, 32'd21);
        chk("mul_wreg", {31'd0, wr}, 32'd1);
        chk("mul_stall", 32'(st), 32'd33);

        op_check("mulh",   1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        op_check("mulhsu", 1, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        op_check("mulhu",  1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        op_check("mul_zero", 1, 3'b000, 32'd0, 32'd5, 32'd0, LAT_FAST);

        op_check("div_neg", 1, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        op_check("rem_neg", 1, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        op_check("divu_z",  1, 3'b101, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, LAT_FAST);
        op_check("rem_z",   1, 3'b110, 32'd5, 32'd0, 32'd5, LAT_FAST);
        op_check("div_ovf", 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST);
        op_check("rem_ovf", 1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_FAST);

        // Flush at T+10 of a DIVU
        func3 = 3'b101; reg1 = 32'd1000; reg2 = 32'd3; wd = 5'd9; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        done_seen = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            if (done1) done_seen++;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (done1) done_seen++;
        chk("flush_stall_t10", {31'd0, stall1}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_stall_t11", {31'd0, stall1}, 32'd0);
        chk("flush_no_done", 32'(done_seen), 32'd0);
        op_check("after_flush", 1, 3'b101, 32'd1000, 32'd3, 32'd333, 33);

        // Reset at T+5 of a MUL
        func3 = 3'b000; reg1 = 32'd9; reg2 = 32'd9; wd = 5'd17; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_stall", {31'd0, stall1}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done1}, 32'd0);
        chk("midrst_wreg", {31'd0, wreg1}, 32'd0);
        chk("midrst_stall", {31'd0, stall1}, 32'd0);
        chk("midrst_wdata", wdata1, 32'd0);
        chk("midrst_wd", {27'd0, wdo1}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        done_seen = 0;
        @(negedge clk);
        chk("postrst_stall", {31'd0, stall1}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) done_seen++;
        end
        chk("postrst_no_done", 32'(done_seen), 32'd0);
        @(posedge clk); #1;
        op_check("postrst_mul", 1, 3'b000, 32'd9, 32'd9, 32'd81, 33);

        // UNROLL = 4: N = 8, done_o at T+9
        op_check("u4_divu", 4, 3'b101, 32'd100, 32'd7, 32'd14, 9);
        op_check("u4_remu", 4, 3'b111, 32'd100, 32'd7, 32'd2, 9);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle execute unit for the RV32M multiply/divide instructions. It sits beside the single-cycle ALU in the EX stage and shares the same operand and destination inputs. It raises `stallreq` while it iterates, then presents a one-cycle write-back result. It generalises the EX datapath in operand width, in iteration radix, and with a sequential mode that the single-cycle ALU does not have.

## Interface
- `XLEN`, 32: operand and result width. Must be an even power of two, at least 8.
- `UNROLL`, 1: quotient or multiplier bits processed per cycle. Legal values are 1, 2 and 4, and `UNROLL` must divide `XLEN`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `start_i` input 1: request a new operation. Sampled only in IDLE.
- `func3_i` input 3: RV32M func3 code.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `reg1_i` input XLEN: rs1 operand (multiplicand or dividend).
- `reg2_i` input XLEN: rs2 operand (multiplier or divisor).
- `wd_i` input 5: destination register address.
- `flush_i` input 1: abort the in-flight operation (branch or flush from later stages).
- `stallreq` output 1: holds the upstream pipeline while the unit is busy.
- `done_o` output 1: result valid, one-cycle pulse.
- `wdata_o` output XLEN: result.
- `wd_o` output 5: destination address latched at start.
- `wreg_o` output 1: register-write enable, equal to `done_o`.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start_i`=1 latches `func3_i`, `wd_i` and both operands.
  - For signed operations it latches the operand magnitudes plus the result-sign flags.
  - It loads counter = XLEN/UNROLL and moves to CALC.
- **CALC**
  - Each cycle performs `UNROLL` shift-add steps (multiply) or restoring-subtract steps (divide), then decrements the counter.
  - When the counter reaches 1, the state moves to DONE on the next edge.
- **DONE**
  - Applies sign fixup and selects the result; `done_o`=`wreg_o`=1 for exactly one cycle.
  - Moves to IDLE on the next edge.
- Multiply: builds an unsigned 2·XLEN product.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half after two's-complement correction of the full 2·XLEN product.
  - Operand signedness: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
- Divide: runs unsigned restoring division on magnitudes.
  - The quotient is negated if the operand signs differ (DIV).
  - The remainder takes the sign of the dividend (REM).
- Divide by zero (divisor 0): the quotient is all-ones for DIV and DIVU, and the remainder equals `reg1_i` for REM and REMU. No sign fixup is applied in this case.
- Signed overflow (dividend −2^(XLEN−1), divisor −1): DIV returns the dividend and REM returns 0.
- `flush_i`=1 in CALC or DONE forces IDLE on the next edge.
  - It suppresses `done_o` in that cycle, because `done_o` is gated by `!flush_i`.
  - `flush_i` in IDLE blocks a simultaneous `start_i`.
- `start_i` in CALC or DONE is ignored. Upstream is stalled, so it must be re-presented.
- `stallreq` = (IDLE & `start_i` & !`flush_i`) | CALC. It is combinational so that the request cycle itself stalls.

## Timing
- Start accepted at edge T. CALC occupies cycles T+1 … T+N, where N = XLEN/UNROLL. `done_o` is high in cycle T+N+1.
- Latency from the start cycle is N+1 cycles. Defaults give 33 cycles.
- Back-to-back: the next `start_i` can be accepted in the first IDLE cycle after DONE, which gives a throughput of one operation per N+2 cycles.
- Outputs are registered except `stallreq`.
- `wdata_o` holds its last value outside DONE; only `done_o` qualifies it.
- Reset values while `rst`=0, taking effect asynchronously:
  - state IDLE, counter 0;
  - `done_o`=0, `wreg_o`=0, `stallreq`=0;
  - `wdata_o`=0, `wd_o`=0.
- Reset mid-CALC discards the operation with no `done_o`.

## Configuration
- `MULDIV_FASTPATH_EN` defined:
  - IDLE detects divide-by-zero, signed overflow, and a zero operand on any multiply.
  - For these cases it goes straight to DONE, giving a latency of 1 cycle (`done_o` in T+1) with the results given above.
  - `stallreq` is asserted only in the start cycle.
- Not defined: every operation takes the full N+1 cycles and produces identical result values.

## Test plan
- MUL 7×(−3), XLEN=32, UNROLL=1 -> `done_o` 33 cycles after start, `wdata_o`=0xFFFFFFEB, `wd_o` as issued, `stallreq` high for cycles T..T+32.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 0x80000000/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/−1 -> 0x80000000 and REM -> 0. With `MULDIV_FASTPATH_EN`, the zero-divisor and overflow cases give `done_o` at T+1.
- `flush_i` pulsed at T+10 of a DIVU -> no `done_o`, `stallreq` low from T+11; a new `start_i` at T+11 completes normally.
- `rst` driven low at T+5 of a MUL -> all outputs 0 immediately and state IDLE; after release, a start gives the correct result.
- UNROLL=4, XLEN=32, DIVU 100/7 -> `done_o` at T+9 with 14; REMU -> 2.
